// File: rtl/fifo_sync_shift_lvl.sv
// Shift-register FIFO with first-word-fall-through head, level count and almost-full/empty flags.
// Define FIFO_SHIFT_ERR_EN to add sticky overflow/underflow error flags cleared by err_clr.
module fifo_sync_shift_lvl #(
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 16,
  parameter int AFULL_LVL  = 3,
  parameter int AEMPTY_LVL = 1,
  localparam int LW        = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             wr_ena,
  output logic             wr_full,
  output logic [WIDTH-1:0] rd_data,
  input  logic             rd_ena,
  output logic             rd_empty,
  input  logic             flush,
  output logic [LW-1:0]    level,
  output logic             afull,
  output logic             aempty,
  output logic             err_ovf,
  output logic             err_udf,
  input  logic             err_clr
);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [WIDTH-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [LW-1:0]    level_q, level_d;
  logic [LW-1:0]    wr_idx;
  logic             rd_acc, wr_acc;

  // Stage 0 is the head; all status flags come straight from flops.
  assign rd_empty = ~valid_q[0];
  assign wr_full  = valid_q[DEPTH-1];
  assign rd_data  = data_q[0];
  assign level    = level_q;
  assign afull    = int'(level_q) >= AFULL_LVL;
  assign aempty   = int'(level_q) <= AEMPTY_LVL;

  assign rd_acc = rd_ena & valid_q[0];
  assign wr_acc = wr_ena & (~valid_q[DEPTH-1] | rd_acc);
  // Free slot after this cycle's shift is exactly the post-read occupancy.
  assign wr_idx = level_q - LW'(rd_acc);

  // NOTE: every variable gets a default at the top so no path leaves it unassigned (no latches).
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    level_d = level_q;
    if (flush) begin
      valid_d = '0;
      level_d = '0;
    end else begin
      if (rd_acc) begin
        // Stages whose upstream neighbour is empty keep their data, so the head
        // holds its last contents rather than picking up stale words.
        for (int i = 0; i < DEPTH - 1; i++) begin
          valid_d[i] = valid_q[i+1];
          if (valid_q[i+1]) data_d[i] = data_q[i+1];
        end
        valid_d[DEPTH-1] = 1'b0;
      end
      if (wr_acc) begin
        for (int i = 0; i < DEPTH; i++) begin
          if (LW'(i) == wr_idx) begin
            data_d[i]  = wr_data;
            valid_d[i] = 1'b1;
          end
        end
      end
      level_d = level_q + LW'(wr_acc) - LW'(rd_acc);
    end
  end

  // NOTE: non-blocking assignments for all flops so every stage samples pre-edge values.
  // NOTE: the data chain is reset as well, so rd_data is a defined 0 out of reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= '0;
      valid_q <= '0;
      level_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) data_q[i] <= data_d[i];
      valid_q <= valid_d;
      level_q <= level_d;
    end
  end

`ifdef FIFO_SHIFT_ERR_EN
  logic err_ovf_q, err_ovf_d;
  logic err_udf_q, err_udf_d;
  logic ovf_set, udf_set;

  // Flush overrides the requests, so neither counts as an error that cycle.
  assign ovf_set = wr_ena & ~wr_acc & ~flush;
  assign udf_set = rd_ena & ~valid_q[0] & ~flush;

  always_comb begin
    err_ovf_d = ovf_set | (err_ovf_q & ~err_clr);
    err_udf_d = udf_set | (err_udf_q & ~err_clr);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_ovf_q <= 1'b0;
      err_udf_q <= 1'b0;
    end else begin
      err_ovf_q <= err_ovf_d;
      err_udf_q <= err_udf_d;
    end
  end

  assign err_ovf = err_ovf_q;
  assign err_udf = err_udf_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_ovf        = 1'b0;
  assign err_udf        = 1'b0;
`endif

endmodule
